// File: rtl/sandpiper_seg7_scan_driver_pkg.sv
// Shared definitions for the Sandpiper 8-digit 7-segment scan driver.
//   - default digit/segment counts and the serial frame width
//   - segment bit positions inside a pattern byte (1 = lit)
//   - scan FSM and serializer state encodings
//   - small helper for clamping derived cycle counts
package sandpiper_seg7_scan_driver_pkg;

   localparam int unsigned SEG_CT_DEF  = 8;
   localparam int unsigned CAN_CT_DEF  = 8;
   localparam int unsigned FRAME_W_DEF = CAN_CT_DEF + SEG_CT_DEF;

   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StShift,
      StLatch,
      StShow
   } scan_state_e;

   typedef enum logic [1:0] {
      SerIdle,
      SerShift,
      SerLatch
   } ser_state_e;

   // Integer division of clock ratios can yield 0; cycle counts never go below 1.
   function automatic int unsigned max1(int unsigned v);
      return (v < 1) ? 1 : v;
   endfunction

endpackage

// File: rtl/sandpiper_seg7_scan_driver_seg7_frame_serializer.sv
// Frame serializer for a daisy-chained 74HC595 pair.
// On start (while idle) it shifts FRAME_W bits MSB first: each bit spends HP cycles with
// sclk low (dout settles there) and HP cycles with sclk high. After the last bit sclk is
// left low and rclk is raised for HP cycles. All pin outputs are registered.
// Ports:
//   sys_clk, rst_n : clock, async active-low reset
//   abort          : synchronous return to idle with all pins low
//   start, frame   : launch a frame (accepted only when not busy)
//   busy           : shifting or latching in progress
//   shift_done     : high in the last shift cycle
//   done           : high in the last latch cycle
//   sclk, dout, rclk : shift-register pins
module sandpiper_seg7_scan_driver_seg7_frame_serializer
   import sandpiper_seg7_scan_driver_pkg::*;
#(
   parameter int unsigned FRAME_W = FRAME_W_DEF,
   parameter int unsigned HP      = 1
) (
   input  logic               sys_clk,
   input  logic               rst_n,
   input  logic               abort,
   input  logic               start,
   input  logic [FRAME_W-1:0] frame,
   output logic               busy,
   output logic               shift_done,
   output logic               done,
   output logic               sclk,
   output logic               dout,
   output logic               rclk
);

   localparam int unsigned DIV_W = $clog2(2 * HP);
   localparam int unsigned BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

   localparam logic [DIV_W-1:0] DIV_HI   = DIV_W'(HP - 1);
   localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(2 * HP - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

   ser_state_e         state_q;
   logic [DIV_W-1:0]   div_q;
   logic [BIT_W-1:0]   bit_q;
   logic [FRAME_W-1:0] shreg_q;

   assign busy       = (state_q != SerIdle);
   assign shift_done = (state_q == SerShift) && (div_q == DIV_END) && (bit_q == BIT_LAST);
   assign done       = (state_q == SerLatch) && (div_q == DIV_HI);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SerIdle;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         sclk    <= 1'b0;
         dout    <= 1'b0;
         rclk    <= 1'b0;
      end else if (abort) begin
         state_q <= SerIdle;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         sclk    <= 1'b0;
         dout    <= 1'b0;
         rclk    <= 1'b0;
      end else begin
         unique case (state_q)
            SerIdle: begin
               if (start) begin
                  // MSB goes straight onto dout; the remainder waits in the shifter.
                  dout    <= frame[FRAME_W-1];
                  shreg_q <= frame << 1;
                  sclk    <= 1'b0;
                  div_q   <= '0;
                  bit_q   <= '0;
                  state_q <= SerShift;
               end
            end
            SerShift: begin
               if (div_q == DIV_HI) begin
                  sclk <= 1'b1;
               end
               if (div_q == DIV_END) begin
                  sclk  <= 1'b0;
                  div_q <= '0;
                  if (bit_q == BIT_LAST) begin
                     dout    <= 1'b0;
                     rclk    <= 1'b1;
                     state_q <= SerLatch;
                  end else begin
                     dout    <= shreg_q[FRAME_W-1];
                     shreg_q <= shreg_q << 1;
                     bit_q   <= bit_q + 1'b1;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            SerLatch: begin
               if (div_q == DIV_HI) begin
                  rclk    <= 1'b0;
                  div_q   <= '0;
                  state_q <= SerIdle;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            default: state_q <= SerIdle;
         endcase
      end
   end

endmodule

// File: rtl/sandpiper_seg7_scan_driver.sv
// Sandpiper 8-digit multiplexed 7-segment driver.
// Holds a per-digit pattern/brightness buffer and scans the digits forever: each slot
// loads {one-hot digit byte, pattern}, shifts it out, latches it and then PWM-dims the
// digit through active-low OE until the slot ends.
// Build option: define SEG7_ACTIVE_LOW_EN for common-anode displays (segment byte is
// inverted before shifting; digit byte unchanged).
// Ports:
//   sys_clk, rst_n      : clock, async active-low reset
//   en                  : 1 = scan, 0 = blank and idle (buffer still writable)
//   clear_buffer        : zero all patterns (wins over a same-cycle commit)
//   commit_char         : write SEGMENTS_2_LIGHT/CHAR_BRIGHTNESS to entry CHAR_SELECTED
//   SCLK, DOUT, RCLK    : shift-register pins
//   OE                  : output enable, active low
module sandpiper_seg7_scan_driver
   import sandpiper_seg7_scan_driver_pkg::*;
#(
   parameter int unsigned DISPLAY_HZ    = 800,
   parameter int unsigned SYSCLK_F      = 24000000,
   parameter int unsigned SHIFT_CLK_F   = 2000000,
   parameter int unsigned CAN_CT        = CAN_CT_DEF,
   parameter int unsigned SEG_CT        = SEG_CT_DEF,
   parameter int unsigned DIMMING_REG_W = 8,
   localparam int unsigned IDX_W        = (CAN_CT > 1) ? $clog2(CAN_CT) : 1
) (
   input  logic                     sys_clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     clear_buffer,
   input  logic                     commit_char,
   input  logic [SEG_CT-1:0]        SEGMENTS_2_LIGHT,
   input  logic [IDX_W-1:0]         CHAR_SELECTED,
   input  logic [DIMMING_REG_W-1:0] CHAR_BRIGHTNESS,
   output logic                     SCLK,
   output logic                     DOUT,
   output logic                     RCLK,
   output logic                     OE
);

   localparam int unsigned SLOT    = SYSCLK_F / (DISPLAY_HZ * CAN_CT);
   localparam int unsigned HP      = max1(SYSCLK_F / (2 * SHIFT_CLK_F));
   localparam int unsigned FRAME_W = CAN_CT + SEG_CT;
   localparam int unsigned CNT_W   = (SLOT > 1) ? $clog2(SLOT) : 1;

   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT - 1);
   localparam logic [IDX_W-1:0] K_LAST    = IDX_W'(CAN_CT - 1);

   // A slot must hold LOAD, 2*FRAME_W half-periods, the latch pulse and one SHOW cycle.
   if (SLOT < 2 + 33 * HP) begin : g_slot_too_short
      $error("slot of %0d cycles cannot hold a frame with HP=%0d", SLOT, HP);
   end

   scan_state_e              state_q;
   logic [IDX_W-1:0]         k_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [DIMMING_REG_W-1:0] pwm_q;
   logic [DIMMING_REG_W-1:0] pwm_next;
   logic [DIMMING_REG_W-1:0] bri_cur_q;
   logic                     oe_q;

   logic [SEG_CT-1:0]        pat_q [CAN_CT];
   logic [DIMMING_REG_W-1:0] bri_q [CAN_CT];

   logic [CAN_CT-1:0]  digit_sel;
   logic [SEG_CT-1:0]  seg_bits;
   logic [FRAME_W-1:0] frame;
   logic               ser_start;
   logic               ser_busy;
   logic               ser_shift_done;
   logic               ser_done;

   // Character buffer; writes are accepted regardless of en.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CAN_CT; i++) begin
            pat_q[i] <= '0;
            bri_q[i] <= '0;
         end
      end else if (clear_buffer) begin
         for (int i = 0; i < CAN_CT; i++) begin
            pat_q[i] <= '0;
         end
      end else if (commit_char && (32'(CHAR_SELECTED) < CAN_CT)) begin
         pat_q[CHAR_SELECTED] <= SEGMENTS_2_LIGHT;
         bri_q[CHAR_SELECTED] <= CHAR_BRIGHTNESS;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_q <= '0;
      end else begin
         pwm_q <= pwm_next;
      end
   end

   assign pwm_next = pwm_q + 1'b1;

   assign digit_sel = CAN_CT'(1) << k_q;
`ifdef SEG7_ACTIVE_LOW_EN
   assign seg_bits = ~pat_q[k_q];
`else
   assign seg_bits = pat_q[k_q];
`endif
   assign frame     = {digit_sel, seg_bits};
   assign ser_start = (state_q == StLoad) && !ser_busy;

   // Scan FSM. oe_q is computed one cycle ahead so OE in a SHOW cycle reflects the PWM
   // count of that same cycle.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         k_q       <= '0;
         cnt_q     <= '0;
         bri_cur_q <= '0;
         oe_q      <= 1'b1;
      end else if (!en) begin
         state_q <= StIdle;
         k_q     <= '0;
         cnt_q   <= '0;
         oe_q    <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_q <= StLoad;
               k_q     <= '0;
               cnt_q   <= '0;
               oe_q    <= 1'b1;
            end
            StLoad: begin
               bri_cur_q <= bri_q[k_q];
               cnt_q     <= cnt_q + 1'b1;
               oe_q      <= 1'b1;
               state_q   <= StShift;
            end
            StShift: begin
               cnt_q <= cnt_q + 1'b1;
               if (ser_shift_done) begin
                  state_q <= StLatch;
               end
            end
            StLatch: begin
               cnt_q <= cnt_q + 1'b1;
               if (ser_done) begin
                  state_q <= StShow;
                  oe_q    <= ~(pwm_next < bri_cur_q);
               end
            end
            StShow: begin
               if (cnt_q == SLOT_LAST) begin
                  state_q <= StLoad;
                  cnt_q   <= '0;
                  oe_q    <= 1'b1;
                  k_q     <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  oe_q  <= ~(pwm_next < bri_cur_q);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign OE = oe_q;

   sandpiper_seg7_scan_driver_seg7_frame_serializer #(
      .FRAME_W (FRAME_W),
      .HP      (HP)
   ) u_serializer (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .abort      (!en),
      .start      (ser_start),
      .frame      (frame),
      .busy       (ser_busy),
      .shift_done (ser_shift_done),
      .done       (ser_done),
      .sclk       (SCLK),
      .dout       (DOUT),
      .rclk       (RCLK)
   );

endmodule

// File: tb/tb_sandpiper_seg7_scan_driver.sv
`timescale 1ns/1ps
module tb_sandpiper_seg7_scan_driver;

   localparam int unsigned SLOT     = 200;
   localparam int unsigned HP       = 2;
   localparam int unsigned SHOW_LEN = SLOT - 1 - 33 * HP;

   logic       sys_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       clear_buffer = 1'b0;
   logic       commit_char = 1'b0;
   logic [7:0] seg_in = '0;
   logic [2:0] idx_in = '0;
   logic [7:0] bri_in = '0;
   logic       sclk, dout, rclk, oe;

   sandpiper_seg7_scan_driver #(
      .DISPLAY_HZ    (1000),
      .SYSCLK_F      (1600000),
      .SHIFT_CLK_F   (400000),
      .CAN_CT        (8),
      .SEG_CT        (8),
      .DIMMING_REG_W (8)
   ) dut (
      .sys_clk          (sys_clk),
      .rst_n            (rst_n),
      .en               (en),
      .clear_buffer     (clear_buffer),
      .commit_char      (commit_char),
      .SEGMENTS_2_LIGHT (seg_in),
      .CHAR_SELECTED    (idx_in),
      .CHAR_BRIGHTNESS  (bri_in),
      .SCLK             (sclk),
      .DOUT             (dout),
      .RCLK             (rclk),
      .OE               (oe)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [15:0] frame;
      logic [7:0]  bri;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  m_pat[8];
   logic [7:0]  m_bri[8];
   int          model_k = 0;
   int unsigned cyc;

   // Cycles since reset release: equals the free-running PWM count modulo 256.
   always @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else cyc <= cyc + 1;
   end

   function automatic void check(string name, int unsigned act, int unsigned expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endfunction

   function automatic logic [15:0] model_frame(int k);
      logic [7:0] digit;
      logic [7:0] seg;
      digit    = '0;
      digit[k] = 1'b1;
`ifdef SEG7_ACTIVE_LOW_EN
      seg = ~m_pat[k];
`else
      seg = m_pat[k];
`endif
      return {digit, seg};
   endfunction

   task automatic push_expected();
      exp_t e;
      e.frame = model_frame(model_k);
      e.bri   = m_bri[model_k];
      exp_q.push_back(e);
      model_k = (model_k + 1) % 8;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_pat[i] = '0;
         m_bri[i] = '0;
      end
   endtask

   // kind: 0 none, 1 commit, 2 clear, 3 clear and commit in the same cycle
   task automatic apply_op(int kind, int idx, logic [7:0] pat, logic [7:0] bri);
      if (kind == 0) return;
      @(negedge sys_clk);
      idx_in       = 3'(idx);
      seg_in       = pat;
      bri_in       = bri;
      commit_char  = (kind == 1 || kind == 3);
      clear_buffer = (kind == 2 || kind == 3);
      @(negedge sys_clk);
      commit_char  = 1'b0;
      clear_buffer = 1'b0;
      if (kind >= 2) begin
         for (int i = 0; i < 8; i++) m_pat[i] = '0;
      end else begin
         m_pat[idx] = pat;
         m_bri[idx] = bri;
      end
   endtask

   task automatic wait_latch(output bit ok);
      logic prev;
      prev = rclk;
      ok   = 1'b0;
      for (int i = 0; i < 3 * SLOT; i++) begin
         @(negedge sys_clk);
         if (rclk && !prev) begin
            ok = 1'b1;
            break;
         end
         prev = rclk;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL latch_timeout: no RCLK rise within %0d cycles", 3 * SLOT);
      end
   endtask

   task automatic wait_sclk_rises(int n);
      logic prev;
      int   seen;
      prev = sclk;
      seen = 0;
      for (int i = 0; i < 3 * SLOT && seen < n; i++) begin
         @(negedge sys_clk);
         if (sclk && !prev) seen++;
         prev = sclk;
      end
      if (seen < n) begin
         checks++;
         errors++;
         $display("FAIL sclk_timeout: saw %0d SCLK rises, needed %0d", seen, n);
      end
   endtask

   // Operations land mid-SHOW, well clear of the next LOAD.
   task automatic run_slot(int kind, int idx, logic [7:0] pat, logic [7:0] bri);
      bit ok;
      wait_latch(ok);
      if (!ok) return;
      repeat (10) @(negedge sys_clk);
      apply_op(kind, idx, pat, bri);
      push_expected();
   endtask

   task automatic check_idle_pins(string tag);
      check({tag, "_sclk"}, 32'(sclk), 0);
      check({tag, "_dout"}, 32'(dout), 0);
      check({tag, "_rclk"}, 32'(rclk), 0);
      check({tag, "_oe"}, 32'(oe), 1);
   endtask

   // Monitor: collects frames on SCLK rises, checks them at RCLK rise, and checks the OE
   // duty during each SHOW window against the PWM rule.
   initial begin : monitor
      logic [15:0] m_bits;
      int unsigned m_nbits, rclk_hi, show_left, show_act, show_exp, outside_low;
      int unsigned last_cyc, d0_cyc;
      logic [7:0]  cur_bri;
      logic        prev_sclk, prev_rclk, have_last, have_d0;
      exp_t        e;
      m_bits = '0; m_nbits = 0; rclk_hi = 0; show_left = 0; show_act = 0; show_exp = 0;
      outside_low = 0; last_cyc = 0; d0_cyc = 0; cur_bri = '0;
      prev_sclk = 1'b0; prev_rclk = 1'b0; have_last = 1'b0; have_d0 = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (!rst_n || !en) begin
            m_bits = '0; m_nbits = 0; rclk_hi = 0; show_left = 0; outside_low = 0;
            prev_sclk = 1'b0; prev_rclk = 1'b0; have_last = 1'b0; have_d0 = 1'b0;
         end else begin
            if (sclk && !prev_sclk) begin
               m_bits = {m_bits[14:0], dout};
               m_nbits++;
            end
            if (rclk && !prev_rclk) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: latched 0x%04h with none expected", m_bits);
               end else begin
                  e = exp_q.pop_front();
                  check("frame", 32'(m_bits), 32'(e.frame));
                  check("bit_count", m_nbits, 16);
                  cur_bri = e.bri;
                  if (have_last) check("slot_period", cyc - last_cyc, SLOT);
                  if (e.frame[8]) begin
                     if (have_d0) check("digit0_period", cyc - d0_cyc, 8 * SLOT);
                     d0_cyc  = cyc;
                     have_d0 = 1'b1;
                  end
               end
               check("oe_dark_outside_show", outside_low, 0);
               outside_low = 0;
               last_cyc    = cyc;
               have_last   = 1'b1;
               m_nbits     = 0;
            end
            if (rclk) rclk_hi++;
            if (!rclk && prev_rclk) begin
               check("rclk_width", rclk_hi, HP);
               rclk_hi   = 0;
               show_left = SHOW_LEN;
               show_act  = 0;
               show_exp  = 0;
            end
            if (show_left > 0) begin
               if (!oe) show_act++;
               if ((cyc % 256) < 32'(cur_bri)) show_exp++;
               show_left--;
               if (show_left == 0) check("oe_low_cycles", show_act, show_exp);
            end else if (!oe) begin
               outside_low++;
            end
            prev_sclk = sclk;
            prev_rclk = rclk;
         end
      end
   end

   initial begin : watchdog
      #(100000 * 10);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int unsigned r;
      int          oe_low;
      model_reset();
      en    = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      check_idle_pins("reset");

      model_k = 0;
      push_expected();
      rst_n = 1'b1;

      // Directed buffer operations, each followed by a full scan of the display.
      run_slot(1, 3, 8'h3F, 8'h80);
      run_slot(1, 1, 8'h06, 8'h10);
      run_slot(1, 7, 8'h5A, 8'hFF);
      run_slot(2, 0, 8'h00, 8'h00);
      run_slot(3, 0, 8'hFF, m_bri[0]);
      for (int i = 0; i < 8; i++) run_slot(0, 0, 8'h00, 8'h00);

      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 9);
         if (r < 2) run_slot(2, 0, 8'h00, 8'h00);
         else if (r < 8) run_slot(1, int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
         else run_slot(0, 0, 8'h00, 8'h00);
      end

      // Drop en in the middle of a shift.
      begin
         bit ok;
         wait_latch(ok);
      end
      wait_sclk_rises(5);
      en = 1'b0;
      exp_q.delete();
      @(negedge sys_clk);
      check_idle_pins("en_drop");
      apply_op(1, 0, 8'h81, 8'h20);
      oe_low = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge sys_clk);
         if (!oe || sclk || rclk || dout) oe_low++;
      end
      check("idle_pins_while_disabled", 32'(oe_low), 0);
      model_k = 0;
      push_expected();
      en = 1'b1;
      for (int i = 0; i < 18; i++) run_slot(0, 0, 8'h00, 8'h00);

      // Asynchronous reset in the middle of a shift.
      begin
         bit ok;
         wait_latch(ok);
      end
      wait_sclk_rises(3);
      #2 rst_n = 1'b0;
      #1 check_idle_pins("async_reset");
      exp_q.delete();
      model_reset();
      repeat (2) @(negedge sys_clk);
      model_k = 0;
      push_expected();
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) run_slot(0, 0, 8'h00, 8'h00);

      @(negedge sys_clk);
      en = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge sys_clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
